// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel state type and ratio helpers for the divider bank
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_e;

    // Ratios below 2 cannot form a high and a low phase, so they are raised to 2
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction

    // High phase length: ceil(n/2), so odd ratios stay high one extra cycle
    function automatic logic [31:0] high_phase(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one integer clock divider with glitch-free ratio change and stop
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    ch_state_e        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] n, n_nxt;
    logic [DIV_W-1:0] pend, pend_nxt;
    logic             pend_v, pend_v_nxt;
    logic             clk_nxt, tick_nxt;
    logic [DIV_W-1:0] ld_val, cnt_inc, commit;
    logic             wrap;

    assign ld_val  = DIV_W'(clamp_div(32'(div)));
    assign cnt_inc = cnt + ONE;
    assign wrap    = (cnt == n - ONE);
    // A load in the wrap cycle itself beats any older pending value
    assign commit  = load ? ld_val : (pend_v ? pend : n);
    assign running = (state != IDLE);

    // Next-state logic: ratio changes and stops only take effect at the wrap
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        n_nxt      = n;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        clk_nxt    = 1'b0;
        tick_nxt   = 1'b0;
        case (state)
            IDLE: begin
                n_nxt = load ? ld_val : n;
                if (en) begin
                    state_nxt = RUN;
                    clk_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = en ? RUN : STOPPING;
                if (wrap) begin
                    cnt_nxt    = '0;
                    n_nxt      = commit;
                    pend_v_nxt = 1'b0;
                    if (state == STOPPING && !en) begin
                        state_nxt = IDLE;
                    end else begin
                        clk_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    clk_nxt = (32'(cnt_inc) < high_phase(32'(n)));
                    if (load) begin
                        pend_nxt   = ld_val;
                        pend_v_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any period in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            n       <= DIV_W'(DEFAULT_DIV);
            pend    <= '0;
            pend_v  <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            n       <= n_nxt;
            pend    <= pend_nxt;
            pend_v  <= pend_v_nxt;
            clk_out <= clk_nxt;
            tick    <= tick_nxt;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent runtime-programmable clock dividers
module clk_div_bank #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       running
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (ch_en[i]),
            .load   (load[i]),
            .div    (div_ratio[i*DIV_W +: DIV_W]),
            .clk_out(clk_out[i]),
            .tick   (tick[i]),
            .running(running[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: table vectors, corner sequences and random stimulus against a period model
module tb_clk_div_bank;

    localparam int NC = 2;
    localparam int DW = 8;
    localparam int DD = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     ch_en = '0;
    logic [NC-1:0]     load = '0;
    logic [NC*DW-1:0]  div_ratio = '0;
    logic [NC-1:0]     clk_out, tick, running;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    int m_act[NC];
    int m_stop[NC];
    int m_pos[NC];
    int m_n[NC];
    int m_pend[NC];

    typedef struct packed {
        logic          rst_n;
        logic [1:0]    en;
        logic [1:0]    ld;
        logic [7:0]    d1;
        logic [1:0]    ck;
        logic [1:0]    tk;
        logic [1:0]    rn;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH     (NC),
        .DIV_W      (DW),
        .DEFAULT_DIV(DD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .div_ratio(div_ratio),
        .load     (load),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    function automatic int clampv(int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Model: each channel is a position inside a period of length n
    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            int d;
            d = int'(div_ratio[c*DW +: DW]);
            if (!rst_n) begin
                m_act[c] = 0; m_stop[c] = 0; m_pos[c] = 0; m_n[c] = DD; m_pend[c] = 0;
            end else if (m_act[c] == 0) begin
                if (load[c]) m_n[c] = clampv(d);
                if (ch_en[c]) begin
                    m_act[c] = 1; m_stop[c] = 0; m_pos[c] = 0;
                end
            end else if (m_pos[c] == m_n[c] - 1) begin
                m_n[c] = load[c] ? clampv(d) : (m_pend[c] != 0 ? m_pend[c] : m_n[c]);
                m_pend[c] = 0;
                m_pos[c] = 0;
                if (m_stop[c] != 0 && !ch_en[c]) m_act[c] = 0;
                m_stop[c] = ch_en[c] ? 0 : 1;
            end else begin
                if (load[c]) m_pend[c] = clampv(d);
                m_pos[c]++;
                m_stop[c] = ch_en[c] ? 0 : 1;
            end
        end
    endtask

    function automatic logic [NC-1:0] e_clk();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = (m_act[c] != 0) && (m_pos[c] < (m_n[c] + 1) / 2);
        return r;
    endfunction

    function automatic logic [NC-1:0] e_tick();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = (m_act[c] != 0) && (m_pos[c] == 0);
        return r;
    endfunction

    function automatic logic [NC-1:0] e_run();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = (m_act[c] != 0);
        return r;
    endfunction

    task automatic check(string nm, int got, int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("clk_out", int'(clk_out), int'(e_clk()));
        check("tick", int'(tick), int'(e_tick()));
        check("running", int'(running), int'(e_run()));
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_pos(int c, int p);
        int k;
        k = 0;
        while (!(m_act[c] != 0 && m_pos[c] == p) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            checks++;
            $display("FAIL wait_pos ch%0d: cnt %0d not reached within 200 cycles", c, p);
        end
    endtask

    // Called right after a ch0 tick; counts cycles to the next ch0 tick
    task automatic tick_period(string nm, int exp);
        int t;
        t = 0;
        do begin
            step();
            t++;
        end while (tick[0] !== 1'b1 && t < 50);
        check(nm, t, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b00, 2'b10, 8'd3, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 2'b10};
        tbl[3]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b10, 2'b00, 2'b10};
        tbl[4]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b00, 2'b00, 2'b10};
        tbl[5]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 2'b10};
        tbl[6]  = '{1'b1, 2'b10, 2'b10, 8'd0, 2'b10, 2'b00, 2'b10};
        tbl[7]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b00, 2'b00, 2'b10};
        tbl[8]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 2'b10};
        tbl[9]  = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b00, 2'b00, 2'b10};
        tbl[10] = '{1'b1, 2'b10, 2'b00, 8'd0, 2'b10, 2'b10, 2'b10};
        tbl[11] = '{1'b1, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 2'b10};
        tbl[12] = '{1'b1, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 2'b00};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 8'd0, 2'b00, 2'b00, 2'b00};

        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n;
            ch_en = tbl[i].en;
            load = tbl[i].ld;
            div_ratio = {tbl[i].d1, 8'd0};
            @(posedge clk);
            model_step();
            cyc++;
            #1;
            check($sformatf("tbl%0d_clk", i), int'(clk_out), int'(tbl[i].ck));
            check($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].tk));
            check($sformatf("tbl%0d_run", i), int'(running), int'(tbl[i].rn));
        end
        load = '0;
        div_ratio = '0;

        // Ratio change mid-period on ch0: 10-cycle period completes, then 4
        rst_n = 1'b0; ch_en = '0;
        step();
        rst_n = 1'b1; ch_en = 2'b01;
        step();
        tick_period("default_period", 10);
        wait_pos(0, 3);
        load = 2'b01; div_ratio[7:0] = 8'd4;
        step();
        load = '0;
        run(30);

        // Load in the wrap cycle applies to the very next period
        wait_pos(0, 3);
        load = 2'b01; div_ratio[7:0] = 8'd6;
        step();
        load = '0;
        tick_period("wrap_load_period", 6);
        run(12);

        // Disable at cnt=2 finishes the period, then re-enable and bounce at cnt=7
        rst_n = 1'b0; ch_en = '0;
        step();
        rst_n = 1'b1; ch_en = 2'b01;
        step();
        wait_pos(0, 2);
        ch_en = '0;
        run(15);
        check("stopped_running", int'(running[0]), 0);
        ch_en = 2'b01;
        step();
        wait_pos(0, 2);
        ch_en = '0;
        wait_pos(0, 7);
        ch_en = 2'b01;
        run(25);

        // Reset mid high phase discards a pending ratio
        wait_pos(0, 1);
        load = 2'b01; div_ratio[7:0] = 8'd4;
        step();
        load = '0;
        rst_n = 1'b0;
        step();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_running", int'(running), 0);
        rst_n = 1'b1;
        step();
        tick_period("post_reset_period", 10);
        run(20);

        // Random traffic on both channels
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 19) == 0) ch_en[c] = ~ch_en[c];
                load[c] = ($urandom_range(0, 15) == 0);
                div_ratio[c*DW +: DW] = 8'($urandom_range(0, 12));
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
